// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for serial_subtractor.
// Master side feeds operands and acknowledges results; slave side is the subtractor.
// Optional signal overflow_o exists only when SERIAL_SUBTRACTOR_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             ready_o;
  logic             valid_o;
  logic             ack_i;
  logic [WIDTH-1:0] diff_o;
  logic             borrow_o;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             overflow_o;
`endif

  modport master (
    output start_i, a_i, b_i, ack_i,
    input  ready_o, valid_o, diff_o,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    input  overflow_o,
`endif
    input  borrow_o
  );

  modport slave (
    input  start_i, a_i, b_i, ack_i,
    output ready_o, valid_o, diff_o,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output overflow_o,
`endif
    output borrow_o
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, D = A - B, LSB first.
// One full-subtractor slice plus a borrow flip-flop is iterated WIDTH times
// over operand shift registers; results are held until acknowledged.
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN adds the signed overflow flag.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  // Only WIDTH-1 result bits need storage; the last bit goes straight to diff.
  logic [WIDTH-2:0] res_reg;
  logic             br_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ready_reg;
  logic             valid_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             a_msb_reg;
  logic             b_msb_reg;
  logic             ovf_reg;
`endif

  // Full-subtractor slice on the current LSBs.
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  assign d_bit    = a_sr_reg[0] ^ b_sr_reg[0] ^ br_reg;
  assign br_next  = (~a_sr_reg[0] & b_sr_reg[0]) | (~(a_sr_reg[0] ^ b_sr_reg[0]) & br_reg);
  assign res_next = {d_bit, res_reg};

  // Control FSM, datapath shifting and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg  <= IDLE;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      res_reg    <= '0;
      br_reg     <= 1'b0;
      cnt_reg    <= '0;
      ready_reg  <= 1'b1;
      valid_reg  <= 1'b0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_reg  <= 1'b0;
      b_msb_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start_i) begin
            a_sr_reg  <= bus.a_i;
            b_sr_reg  <= bus.b_i;
            res_reg   <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb_reg <= bus.a_i[WIDTH-1];
            b_msb_reg <= bus.b_i[WIDTH-1];
`endif
            state_reg <= SHIFT;
          end
        end

        SHIFT: begin
          a_sr_reg <= {1'b0, a_sr_reg[WIDTH-1:1]};
          b_sr_reg <= {1'b0, b_sr_reg[WIDTH-1:1]};
          res_reg  <= res_next[WIDTH-1:1];
          br_reg   <= br_next;
          if (cnt_reg == LAST_CNT) begin
            // MSB slice: publish the result and its borrow.
            diff_reg   <= res_next;
            borrow_reg <= br_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_reg    <= (a_msb_reg != b_msb_reg) && (d_bit != a_msb_reg);
`endif
            valid_reg  <= 1'b1;
            state_reg  <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        DONE: begin
          // start_i is ignored here since ready is low.
          if (bus.ack_i) begin
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ready_o  = ready_reg;
  assign bus.valid_o  = valid_reg;
  assign bus.diff_o   = diff_reg;
  assign bus.borrow_o = borrow_reg;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign bus.overflow_o = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8), directed vectors
// plus a back-to-back run of random operand pairs.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_subtractor_if #(.WIDTH(WIDTH)) sif ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for valid_o; returns cycles counted after the accept edge.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (sif.valid_o !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Called at a negedge with ready_o=1; returns at a negedge with ready_o=1.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic eb, input logic eo);
    int cyc;
    sif.a_i     = a;
    sif.b_i     = b;
    sif.start_i = 1'b1;
    @(negedge clk);
    sif.start_i = 1'b0;
    sif.a_i     = ~a;
    sif.b_i     = ~b;
    check({tag, " ready low"}, 32'(sif.ready_o), 32'd0);
    wait_valid(cyc);
    check({tag, " latency"}, 32'(cyc), 32'd8);
    check({tag, " diff"}, 32'(sif.diff_o), 32'(ed));
    check({tag, " borrow"}, 32'(sif.borrow_o), 32'(eb));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check({tag, " ovf"}, 32'(sif.overflow_o), 32'(eo));
`endif
    $display("op %s a=%02h b=%02h diff=%02h borrow=%0d exp_diff=%02h exp_borrow=%0d exp_ovf=%0d",
             tag, a, b, sif.diff_o, sif.borrow_o, ed, eb, eo);
    sif.ack_i = 1'b1;
    @(negedge clk);
    sif.ack_i = 1'b0;
    check({tag, " valid cleared"}, 32'(sif.valid_o), 32'd0);
    check({tag, " ready back"}, 32'(sif.ready_o), 32'd1);
  endtask

  initial begin
    int cyc;
    logic [7:0] ra, rb, rd;
    logic       rov;

    rst_n       = 1'b0;
    sif.start_i = 1'b0;
    sif.ack_i   = 1'b0;
    sif.a_i     = '0;
    sif.b_i     = '0;
    repeat (2) @(negedge clk);
    check("reset ready", 32'(sif.ready_o), 32'd1);
    check("reset valid", 32'(sif.valid_o), 32'd0);
    check("reset diff", 32'(sif.diff_o), 32'd0);
    check("reset borrow", 32'(sif.borrow_o), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check("reset ovf", 32'(sif.overflow_o), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-computed results.
    do_op("v05m03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    do_op("v03m05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    do_op("v00m00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    do_op("vFFmFF", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    do_op("v80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    do_op("v7FmFF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // Start ignored during SHIFT, result held while ack is low.
    sif.a_i = 8'h10; sif.b_i = 8'h01; sif.start_i = 1'b1;
    @(negedge clk);
    sif.start_i = 1'b0;
    repeat (3) @(negedge clk);
    sif.a_i = 8'h20; sif.b_i = 8'h02; sif.start_i = 1'b1;
    @(negedge clk);
    sif.start_i = 1'b0;
    check("busy ready low", 32'(sif.ready_o), 32'd0);
    wait_valid(cyc);
    check("hold valid seen", 32'(sif.valid_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("hold diff", 32'(sif.diff_o), 32'h0F);
      check("hold valid", 32'(sif.valid_o), 32'd1);
      check("hold borrow", 32'(sif.borrow_o), 32'd0);
      @(negedge clk);
    end
    $display("op hold a=10 b=01 diff=%02h (second start ignored)", sif.diff_o);
    sif.ack_i = 1'b1; sif.start_i = 1'b1;
    @(negedge clk);
    sif.ack_i = 1'b0; sif.start_i = 1'b0;
    check("ack+start ready", 32'(sif.ready_o), 32'd1);
    check("ack+start valid", 32'(sif.valid_o), 32'd0);
    @(negedge clk);
    check("no new op ready", 32'(sif.ready_o), 32'd1);
    check("retained diff", 32'(sif.diff_o), 32'h0F);

    // Asynchronous reset in the middle of SHIFT.
    sif.a_i = 8'hAA; sif.b_i = 8'h55; sif.start_i = 1'b1;
    @(negedge clk);
    sif.start_i = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort ready", 32'(sif.ready_o), 32'd1);
    check("abort valid", 32'(sif.valid_o), 32'd0);
    check("abort diff", 32'(sif.diff_o), 32'd0);
    $display("op abort a=aa b=55 reset mid-shift");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("vAAm55", 8'hAA, 8'h55, 8'h55, 1'b0, 1'b1);

    // Back-to-back random pairs, ack on the cycle valid rises.
    for (int n = 0; n < 256; n++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rd  = ra - rb;
      rov = (ra[7] != rb[7]) && (rd[7] != ra[7]);
      do_op("rand", ra, rb, rd, (ra < rb), rov);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor, D = A - B. It is the inverse counterpart of the combinational full-adder cell.
- One full-subtractor bit-slice plus a borrow flip-flop is iterated WIDTH times over shift registers, LSB first.
- Start/ready and valid/ack handshakes let a testbench or controller feed operands and collect results.
- Sits alongside the adder blocks as the area-minimal arithmetic option.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk_i  input  1  system clock; all state updates on rising edge.
- rst_n_i  input  1  asynchronous active-low reset; assertion clears all state immediately, deassertion is synchronous to clk_i.
- start_i  input  1  request; sampled only while ready_o=1.
- a_i  input  WIDTH  minuend; captured on the accepted start.
- b_i  input  WIDTH  subtrahend; captured on the accepted start.
- ready_o  output  1  block idle, start accepted.
- valid_o  output  1  result available; held until ack_i.
- ack_i  input  1  consumer accepts result; sampled only while valid_o=1.
- diff_o  output  WIDTH  A - B modulo 2^WIDTH.
- borrow_o  output  1  unsigned borrow out, 1 when A < B unsigned.

Behaviour:
- Reset values: ready_o=1, valid_o=0, diff_o=0, borrow_o=0. Internal state: FSM=IDLE, counter=0, borrow FF=0, shift regs=0.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT: on an edge with start_i=1.
  - Load a_i/b_i into shift regs A_sr/B_sr.
  - Clear the result shift reg, the borrow FF and the counter.
  - ready_o falls on the same edge.
- SHIFT, per cycle:
  - d = A_sr[0] ^ B_sr[0] ^ br
  - br_next = (~A_sr[0] & B_sr[0]) | (~(A_sr[0] ^ B_sr[0]) & br)
  - d is shifted into the result MSB; A_sr and B_sr shift right; counter increments.
- SHIFT -> DONE: on the edge where counter == WIDTH-1.
  - diff_o = final result register; borrow_o = br_next of the MSB slice.
  - valid_o rises.
- Latency: valid_o is high exactly WIDTH cycles after the start-accept edge. Throughput is one operation per WIDTH+2 cycles with immediate ack.
- DONE: diff_o, borrow_o and valid_o stay stable while ack_i=0. On ack_i=1: valid_o falls, ready_o rises, next state IDLE. diff_o/borrow_o retain their values until the next accepted start.
- start_i while ready_o=0 (SHIFT or DONE) is ignored; it is not queued.
- start_i and ack_i both high in DONE: ack is honoured; start is ignored because ready_o=0 that cycle.
- ack_i outside DONE is ignored.
- a_i/b_i may change freely after the accept edge without affecting the result.
- Reset mid-operation (SHIFT or DONE): immediate abort to reset values. No partial result is presented.
- No counter wrap: the counter is bounded by WIDTH-1 and cleared on every start.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined: adds output port overflow_o (1 bit).
  - Reset value 0.
  - Updated with diff_o on SHIFT -> DONE.
  - overflow_o = signed two's-complement overflow = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]), from captured operand MSBs and the final result MSB.
  - Held in DONE; retained like diff_o.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan (WIDTH=8):
- Reset, then A=0x05, B=0x03, start pulse, ack after valid -> valid_o high 8 cycles after accept; diff_o=0x02, borrow_o=0; overflow_o=0 if enabled.
- A=0x03, B=0x05 -> diff_o=0xFE, borrow_o=1. Then A=0x00, B=0x00 -> diff_o=0x00, borrow_o=0. Then A=0xFF, B=0xFF -> diff_o=0x00, borrow_o=0.
- A=0x80, B=0x01 with SERIAL_SUBTRACTOR_OVF_EN -> diff_o=0x7F, borrow_o=0, overflow_o=1. Also A=0x7F, B=0xFF -> diff_o=0x80, borrow_o=1, overflow_o=1.
- Start A=0x10, B=0x01; during SHIFT pulse start_i with A=0x20, B=0x02; hold ack_i=0 for 5 cycles in DONE.
  - Expect diff_o=0x0F, stable throughout.
  - valid_o stays high until ack; second start not executed.
  - Also drive ack_i and start_i together in DONE: expect IDLE next, no new operation.
- Start A=0xAA, B=0x55; assert rst_n_i low asynchronously at cycle 4 of SHIFT.
  - Expect ready_o=1, valid_o=0, diff_o=0x00 immediately.
  - A new start A=0xAA, B=0x55 after reset yields diff_o=0x55, borrow_o=0.
- Back-to-back: 256 random operand pairs with ack on the same cycle valid rises -> each result matches a - b modulo 256 and borrow = (a < b); start accepted on the cycle after ack.
